// File: rtl/sysid_checker_pkg.sv
// Shared types and constants for the system-ID boot checker.
package sysid_checker_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RD_ID = 2'd1,
    RD_TS = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic SYSID_ADDR_ID = 1'b0;
  localparam logic SYSID_ADDR_TS = 1'b1;

endpackage

// File: rtl/sysid_checker.sv
// Avalon-MM master that reads sysid words 0/1 after reset and flags whether
// they match the build this image expects.
module sysid_checker
  import sysid_checker_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID        = 32'd0,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1586464125,
  parameter int          TIMEOUT_CYCLES     = 255,
  parameter int          AUTO_START         = 1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  output logic [31:0] id_value,
  output logic [31:0] ts_value,
  output logic        done,
  output logic        match,
  output logic        timeout
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYCLES);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          read_q, read_d;
  logic          addr_q, addr_d;
  logic [31:0]   id_q, id_d;
  logic [31:0]   ts_q, ts_d;
  logic          done_q, done_d;
  logic          match_q, match_d;
  logic          tmo_q, tmo_d;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      read_q  <= 1'b0;
      addr_q  <= SYSID_ADDR_ID;
      id_q    <= '0;
      ts_q    <= '0;
      done_q  <= 1'b0;
      match_q <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      read_q  <= read_d;
      addr_q  <= addr_d;
      id_q    <= id_d;
      ts_q    <= ts_d;
      done_q  <= done_d;
      match_q <= match_d;
      tmo_q   <= tmo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    read_d  = read_q;
    addr_d  = addr_q;
    id_d    = id_q;
    ts_d    = ts_q;
    done_d  = done_q;
    match_d = match_q;
    tmo_d   = tmo_q;
    case (state_q)
      IDLE: begin
        if (AUTO_START != 0 || start) begin
          state_d = RD_ID;
          read_d  = 1'b1;
          addr_d  = SYSID_ADDR_ID;
          cnt_d   = '0;
        end
      end
      RD_ID, RD_TS: begin
        if (!avm_waitrequest) begin
          cnt_d = '0;
          if (state_q == RD_ID) begin
            id_d    = avm_readdata;
            state_d = RD_TS;
            addr_d  = SYSID_ADDR_TS;
          end else begin
            ts_d    = avm_readdata;
            state_d = DONE;
            read_d  = 1'b0;
            addr_d  = SYSID_ADDR_ID;
            done_d  = 1'b1;
            tmo_d   = 1'b0;
            match_d = (id_q == EXPECTED_ID) && (avm_readdata == EXPECTED_TIMESTAMP);
          end
        end else if (cnt_q == CNT_MAX) begin
          // Abandon the read; whichever word was not captured stays 0.
          state_d = DONE;
          read_d  = 1'b0;
          addr_d  = SYSID_ADDR_ID;
          done_d  = 1'b1;
          tmo_d   = 1'b1;
          match_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        if (start) begin
          state_d = RD_ID;
          read_d  = 1'b1;
          addr_d  = SYSID_ADDR_ID;
          cnt_d   = '0;
          id_d    = '0;
          ts_d    = '0;
          done_d  = 1'b0;
          match_d = 1'b0;
          tmo_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign avm_address = addr_q;
  assign avm_read    = read_q;
  assign id_value    = id_q;
  assign ts_value    = ts_q;
  assign done        = done_q;
  assign match       = match_q;
  assign timeout     = tmo_q;

endmodule
